// File: rtl/pkg_audio.sv
// rtl/pkg_audio.sv - shared audio frame types and FIFO state encoding
package pkg_audio;

  localparam int FRAME_BITS = 32;

  typedef struct packed {
    logic [15:0] left;
    logic [15:0] right;
  } audio_frame_t;

  typedef enum logic {
    PRIME = 1'b0,
    RUN   = 1'b1
  } fifo_state_t;

endpackage

// File: rtl/mod_pulse_sync.sv
// rtl/mod_pulse_sync.sv - two-flop synchronizer with rising-edge detect
module mod_pulse_sync (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_async,
  output logic o_pulse
);

  logic sync_1;
  logic sync_2;
  logic sync_prev;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sync_1    <= 1'b0;
      sync_2    <= 1'b0;
      sync_prev <= 1'b0;
    end else begin
      sync_1    <= i_async;
      sync_2    <= sync_1;
      sync_prev <= sync_2;
    end
  end

  // One cycle wide however long the async level stays high
  assign o_pulse = sync_2 & ~sync_prev;

endmodule

// File: rtl/mod_dac_sample_fifo.sv
// rtl/mod_dac_sample_fifo.sv - priming sample FIFO feeding the DAC serializer
module mod_dac_sample_fifo
  import pkg_audio::*;
#(
  parameter int DEPTH       = 16,
  parameter int PRIME_LEVEL = 8
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [FRAME_BITS-1:0]   i_wr_data,
  input  logic                    i_wr_valid,
  output logic                    o_wr_ready,
  input  logic                    i_dac_done,
  output logic [FRAME_BITS-1:0]   o_dac_data,
  output logic [$clog2(DEPTH):0]  o_level,
  output logic                    o_playing,
  output logic                    o_underrun,
  input  logic                    i_clr_underrun
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  audio_frame_t mem [DEPTH];
  audio_frame_t dac_data;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] level;
  logic [LW-1:0] level_next;
  fifo_state_t   state;
  fifo_state_t   state_next;
  logic          pop_req;
  logic          push;
  logic          pop;
  logic          underrun_ev;

  mod_pulse_sync u_done_sync (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_async (i_dac_done),
    .o_pulse (pop_req)
  );

  assign o_wr_ready  = (level != LW'(DEPTH));
  assign push        = i_wr_valid && o_wr_ready;
  assign pop         = (state == RUN) && pop_req && (level != '0);
  assign underrun_ev = (state == RUN) && pop_req && (level == '0);

  always_comb begin
    level_next = level;
    if (push && !pop) begin
      level_next = level + LW'(1);
    end else if (!push && pop) begin
      level_next = level - LW'(1);
    end
  end

  // Priming looks at the post-push level so playback starts on the filling edge
  always_comb begin
    state_next = state;
    case (state)
      PRIME:   if (level_next >= LW'(PRIME_LEVEL)) state_next = RUN;
      RUN:     if (underrun_ev) state_next = PRIME;
      default: state_next = PRIME;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= PRIME;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) begin
      mem[wr_ptr] <= i_wr_data;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      dac_data   <= '0;
      o_underrun <= 1'b0;
    end else begin
      level <= level_next;
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        dac_data <= mem[rd_ptr];
        rd_ptr   <= rd_ptr + AW'(1);
      end else if (underrun_ev) begin
        dac_data <= '0;
      end
      if (underrun_ev) begin
        o_underrun <= 1'b1;
      end else if (i_clr_underrun) begin
        o_underrun <= 1'b0;
      end
    end
  end

  assign o_dac_data = dac_data;
  assign o_level    = level;
  assign o_playing  = (state == RUN);

endmodule

// File: tb/tb_mod_dac_sample_fifo.sv
// tb/tb_mod_dac_sample_fifo.sv - scoreboard bench for mod_dac_sample_fifo
module tb_mod_dac_sample_fifo;

  localparam int DEPTH = 16;
  localparam int PRIME = 8;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic [31:0] i_wr_data = '0;
  logic        i_wr_valid = 1'b0;
  logic        o_wr_ready;
  logic        i_dac_done = 1'b0;
  logic [31:0] o_dac_data;
  logic [4:0]  o_level;
  logic        o_playing;
  logic        o_underrun;
  logic        i_clr_underrun = 1'b0;

  int          n_checks = 0;
  int          n_pass = 0;
  logic [31:0] model_q[$];
  logic [31:0] exp_q[$];
  bit          model_run = 1'b0;
  logic [31:0] prev_data = '0;

  mod_dac_sample_fifo #(.DEPTH(DEPTH), .PRIME_LEVEL(PRIME)) dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_wr_data      (i_wr_data),
    .i_wr_valid     (i_wr_valid),
    .o_wr_ready     (o_wr_ready),
    .i_dac_done     (i_dac_done),
    .o_dac_data     (o_dac_data),
    .o_level        (o_level),
    .o_playing      (o_playing),
    .o_underrun     (o_underrun),
    .i_clr_underrun (i_clr_underrun)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Monitor: every change of the serializer word must match the next scoreboard entry
  always @(negedge i_clk) begin
    if (i_rst) begin
      prev_data = o_dac_data;
    end else if (o_dac_data !== prev_data) begin
      if (exp_q.size() == 0) check("unexpected_dac_data", o_dac_data, prev_data);
      else check("dac_data_order", o_dac_data, exp_q.pop_front());
      prev_data = o_dac_data;
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic push(input logic [31:0] d);
    bit acc;
    acc = (model_q.size() < DEPTH);
    i_wr_valid = 1'b1;
    i_wr_data  = d;
    tick();
    i_wr_valid = 1'b0;
    if (acc) begin
      model_q.push_back(d);
      if (!model_run && model_q.size() >= PRIME) model_run = 1'b1;
    end
  endtask

  // Done pulse; optional clear and push land on the same edge as the resulting pop
  task automatic done_pulse(input int hold, input bit clr, input bit do_push, input logic [31:0] pd);
    bit popped;
    bit acc;
    popped = 1'b0;
    if (model_run) begin
      if (model_q.size() > 0) begin
        exp_q.push_back(model_q.pop_front());
        popped = 1'b1;
      end else begin
        exp_q.push_back(32'h0);
        model_run = 1'b0;
      end
    end
    acc = (model_q.size() + (popped ? 1 : 0)) < DEPTH;
    i_dac_done = 1'b1;
    tick();
    tick();
    i_clr_underrun = clr;
    i_wr_valid = do_push;
    i_wr_data  = pd;
    tick();
    i_clr_underrun = 1'b0;
    i_wr_valid = 1'b0;
    if (do_push && acc) begin
      model_q.push_back(pd);
      if (!model_run && model_q.size() >= PRIME) model_run = 1'b1;
    end
    repeat (hold) tick();
    i_dac_done = 1'b0;
    repeat (3) tick();
  endtask

  initial begin
    repeat (2) @(posedge i_clk);
    #1;
    check("rst_level", 32'(o_level), 32'd0);
    check("rst_dac_data", o_dac_data, 32'h0);
    i_rst = 1'b0;
    tick();
    check("rst_wr_ready", 32'(o_wr_ready), 32'd1);
    check("rst_playing", 32'(o_playing), 32'd0);
    check("rst_underrun", 32'(o_underrun), 32'd0);

    // Test 1: prime with 8 frames
    for (int i = 1; i <= 7; i++) push({16'(i), 16'(i)});
    check("t1_not_playing_at_7", 32'(o_playing), 32'd0);
    push(32'h0008_0008);
    check("t1_playing_at_8", 32'(o_playing), 32'd1);
    check("t1_dac_still_0", o_dac_data, 32'h0);
    check("t1_level_8", 32'(o_level), 32'd8);

    // Test 2: first pop three edges after done, long hold pops once
    exp_q.push_back(model_q.pop_front());
    i_dac_done = 1'b1;
    tick();
    tick();
    check("t2_before_third_edge", o_dac_data, 32'h0);
    tick();
    check("t2_first_frame", o_dac_data, 32'h0001_0001);
    check("t2_level_7", 32'(o_level), 32'd7);
    repeat (50) tick();
    check("t2_single_pop", 32'(o_level), 32'd7);
    i_dac_done = 1'b0;
    repeat (3) tick();

    // Test 3: fill to full, a 17th frame is refused
    for (int i = 9; i <= 17; i++) push({16'(i), 16'(i)});
    check("t3_level_full", 32'(o_level), 32'd16);
    check("t3_wr_ready_low", 32'(o_wr_ready), 32'd0);
    push(32'hDEAD_BEEF);
    check("t3_level_after_17th", 32'(o_level), 32'd16);

    // Test 4: drain, underrun, re-prime, clear
    while (model_q.size() > 0) done_pulse(0, 1'b0, 1'b0, '0);
    check("t4_drained_level", 32'(o_level), 32'd0);
    done_pulse(0, 1'b0, 1'b0, '0);
    check("t4_underrun_data", o_dac_data, 32'h0);
    check("t4_underrun_flag", 32'(o_underrun), 32'd1);
    check("t4_underrun_stop", 32'(o_playing), 32'd0);
    for (int i = 0; i < 7; i++) push(32'h2000_0000 + 32'(i));
    check("t4_reprime_7", 32'(o_playing), 32'd0);
    push(32'h2000_0007);
    check("t4_reprime_8", 32'(o_playing), 32'd1);
    i_clr_underrun = 1'b1;
    tick();
    i_clr_underrun = 1'b0;
    check("t4_clear", 32'(o_underrun), 32'd0);
    while (model_q.size() > 0) done_pulse(0, 1'b0, 1'b0, '0);
    // Underrun coinciding with clear and a push: flag set, frame kept
    done_pulse(0, 1'b1, 1'b1, 32'h5555_AAAA);
    check("t4_set_wins", 32'(o_underrun), 32'd1);
    check("t4_push_stored", 32'(o_level), 32'd1);
    check("t4_reprimed_off", 32'(o_playing), 32'd0);

    // Test 5: level 5 in RUN, simultaneous push/pop across wrap
    for (int i = 1; i <= 7; i++) push(32'h3000_0000 + 32'(i));
    check("t5_running", 32'(o_playing), 32'd1);
    repeat (3) done_pulse(0, 1'b0, 1'b0, '0);
    check("t5_level_5", 32'(o_level), 32'd5);
    done_pulse(0, 1'b0, 1'b1, 32'hC000_0000);
    check("t5_level_same", 32'(o_level), 32'd5);
    for (int i = 1; i < 40; i++) done_pulse(0, 1'b0, 1'b1, 32'hC000_0000 + 32'(i));
    check("t5_level_after_40", 32'(o_level), 32'd5);

    // Test 6: asynchronous reset mid-stream with level 9
    for (int i = 0; i < 4; i++) push(32'hD000_0000 + 32'(i));
    check("t6_level_9", 32'(o_level), 32'd9);
    #2;
    i_rst = 1'b1;
    #1;
    check("t6_async_level", 32'(o_level), 32'd0);
    check("t6_async_data", o_dac_data, 32'h0);
    check("t6_async_playing", 32'(o_playing), 32'd0);
    check("t6_async_underrun", 32'(o_underrun), 32'd0);
    check("t6_async_wr_ready", 32'(o_wr_ready), 32'd1);
    model_q.delete();
    model_run = 1'b0;
    #23;
    i_rst = 1'b0;
    tick();
    for (int i = 1; i <= 8; i++) push(32'hB000_0000 + 32'(i));
    done_pulse(0, 1'b0, 1'b0, '0);
    check("t6_first_after_reset", o_dac_data, 32'hB000_0001);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
